// File: rtl/dcache_ctrl_mp.sv
// Multi-port data-cache controller: zero-latency load hits, miss/evict enqueue into the MSHR,
// single write-port arbitration (fill > flush > store) and the end-of-program flush walk.
module dcache_ctrl_mp #(
    parameter int NUM_LD    = 2,
    parameter int NUM_LINES = 32,
    parameter int WADDR_W   = 61,
    parameter int DATA_W    = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_LD-1:0]             ld_en,
    input  logic [NUM_LD*WADDR_W-1:0]     ld_waddr,
    input  logic [NUM_LD-1:0]             ld_hit,
    input  logic [NUM_LD*DATA_W-1:0]      ld_rdata,
    output logic [NUM_LD-1:0]             ld_valid,
    output logic [NUM_LD*DATA_W-1:0]      ld_value,
    input  logic                          st_en,
    input  logic [WADDR_W-1:0]            st_waddr,
    input  logic [DATA_W-1:0]             st_data,
    input  logic                          st_wr_hit,
    output logic                          st_done,
    input  logic                          fill_en,
    input  logic [WADDR_W-1:0]            fill_waddr,
    input  logic [DATA_W-1:0]             fill_data,
    input  logic                          fill_dirty,
    output logic                          fill_ack,
    output logic                          wr_en,
    output logic                          wr_valid,
    output logic                          wr_dirty,
    output logic [WADDR_W-1:0]            wr_waddr,
    output logic [DATA_W-1:0]             wr_data,
    input  logic                          ev_valid,
    input  logic                          ev_dirty,
    input  logic [WADDR_W-1:0]            ev_waddr,
    input  logic [DATA_W-1:0]             ev_data,
    input  logic                          mshr_ready,
    input  logic                          mshr_empty,
    input  logic [NUM_LD:0]               mshr_addr_hit,
    output logic [NUM_LD+1:0]             miss_en,
    output logic [(NUM_LD+2)*WADDR_W-1:0] miss_waddr,
    output logic [(NUM_LD+2)*DATA_W-1:0]  miss_data,
    input  logic                          flush_req,
    output logic                          flushing,
    output logic                          halt
);
    localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [DATA_W-1:0] LD_MISS_DATA = DATA_W'(64'hDEADBEEFDEADBEEF);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              rst_q;

    logic              active, fill_own, flush_own, st_own, flush_wr, st_enq, ev_enq;
    logic [NUM_LD-1:0] ld_miss, ld_dup, ld_enq;

    // Outputs stay quiet during reset and the cycle after it.
    assign active    = !(reset || rst_q);
    assign fill_own  = active && fill_en && mshr_ready;
    assign flush_own = active && (state_q == S_FLUSH) && !fill_own;
    assign st_own    = active && (state_q == S_IDLE) && st_en && !fill_own;
    assign flush_wr  = flush_own && mshr_ready;
    assign st_enq    = st_own && !st_wr_hit && !mshr_addr_hit[NUM_LD] && mshr_ready;
    assign ev_enq    = wr_en && (fill_own || flush_own) && ev_valid && ev_dirty;

    assign fill_ack  = fill_own;
    assign st_done   = st_own && (st_wr_hit || st_enq);
    assign ld_valid  = active ? (ld_en & ld_hit) : '0;
    assign ld_value  = active ? ld_rdata : '0;
    assign flushing  = active && ((state_q == S_FLUSH) || (state_q == S_DRAIN));
    assign halt      = active && (state_q == S_DONE) && mshr_empty;

    always_ff @(posedge clock) begin
        rst_q <= reset;
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else if (!rst_q) begin
            case (state_q)
                S_IDLE: if (flush_req) begin
                    state_q <= S_FLUSH;
                    idx_q   <= '0;
                end
                S_FLUSH: if (flush_wr) begin
                    if (idx_q == IDX_W'(NUM_LINES - 1)) state_q <= S_DRAIN;
                    else                                 idx_q   <= idx_q + IDX_W'(1);
                end
                S_DRAIN: if (mshr_empty) state_q <= S_DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
        wr_waddr = '0;
        wr_data  = '0;
        if (fill_own) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_dirty = fill_dirty;
            wr_waddr = fill_waddr;
            wr_data  = fill_data;
        end else if (flush_own) begin
            // Invalidating write; the array reports the victim for eviction.
            wr_en    = mshr_ready;
            wr_waddr = WADDR_W'(idx_q);
        end else if (st_own) begin
            wr_en    = st_wr_hit;
            wr_valid = 1'b1;
            wr_dirty = 1'b1;
            wr_waddr = st_waddr;
            wr_data  = st_data;
        end
    end

    // Same-cycle misses to one address are merged onto the lowest port.
    always_comb begin
        ld_miss = ld_en & ~ld_hit;
        ld_dup  = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            for (int j = 0; j < NUM_LD; j++) begin
                if (j < i && ld_miss[j] &&
                    ld_waddr[j*WADDR_W +: WADDR_W] == ld_waddr[i*WADDR_W +: WADDR_W])
                    ld_dup[i] = 1'b1;
            end
        end
        ld_enq = (active && state_q == S_IDLE && mshr_ready) ?
                 (ld_miss & ~mshr_addr_hit[NUM_LD-1:0] & ~ld_dup) : '0;
    end

    always_comb begin
        miss_en    = '0;
        miss_waddr = '0;
        miss_data  = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            if (ld_enq[i]) begin
                miss_en[i]                       = 1'b1;
                miss_waddr[i*WADDR_W +: WADDR_W] = ld_waddr[i*WADDR_W +: WADDR_W];
                miss_data[i*DATA_W +: DATA_W]    = LD_MISS_DATA;
            end
        end
        if (st_enq) begin
            miss_en[NUM_LD]                       = 1'b1;
            miss_waddr[NUM_LD*WADDR_W +: WADDR_W] = st_waddr;
            miss_data[NUM_LD*DATA_W +: DATA_W]    = st_data;
        end
        if (ev_enq) begin
            miss_en[NUM_LD+1]                         = 1'b1;
            miss_waddr[(NUM_LD+1)*WADDR_W +: WADDR_W] = ev_waddr;
            miss_data[(NUM_LD+1)*DATA_W +: DATA_W]    = ev_data;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl_mp.sv
// Bench for dcache_ctrl_mp: directed scenarios plus random traffic, scored against a
// behavioural model through an expectation queue drained by a separate monitor.
module tb_dcache_ctrl_mp;
    localparam int L      = 2;
    localparam int NLINES = 4;
    localparam int AW     = 61;
    localparam int DW     = 64;

    logic                  clock, reset;
    logic [L-1:0]          ld_en, ld_hit, ld_valid;
    logic [L*AW-1:0]       ld_waddr;
    logic [L*DW-1:0]       ld_rdata, ld_value;
    logic                  st_en, st_wr_hit, st_done;
    logic [AW-1:0]         st_waddr, fill_waddr, wr_waddr, ev_waddr;
    logic [DW-1:0]         st_data, fill_data, wr_data, ev_data;
    logic                  fill_en, fill_dirty, fill_ack;
    logic                  wr_en, wr_valid, wr_dirty, ev_valid, ev_dirty;
    logic                  mshr_ready, mshr_empty;
    logic [L:0]            mshr_addr_hit;
    logic [L+1:0]          miss_en;
    logic [(L+2)*AW-1:0]   miss_waddr;
    logic [(L+2)*DW-1:0]   miss_data;
    logic                  flush_req, flushing, halt;

    dcache_ctrl_mp #(.NUM_LD(L), .NUM_LINES(NLINES), .WADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .ld_en(ld_en), .ld_waddr(ld_waddr), .ld_hit(ld_hit), .ld_rdata(ld_rdata),
        .ld_valid(ld_valid), .ld_value(ld_value),
        .st_en(st_en), .st_waddr(st_waddr), .st_data(st_data), .st_wr_hit(st_wr_hit),
        .st_done(st_done),
        .fill_en(fill_en), .fill_waddr(fill_waddr), .fill_data(fill_data),
        .fill_dirty(fill_dirty), .fill_ack(fill_ack),
        .wr_en(wr_en), .wr_valid(wr_valid), .wr_dirty(wr_dirty), .wr_waddr(wr_waddr),
        .wr_data(wr_data),
        .ev_valid(ev_valid), .ev_dirty(ev_dirty), .ev_waddr(ev_waddr), .ev_data(ev_data),
        .mshr_ready(mshr_ready), .mshr_empty(mshr_empty), .mshr_addr_hit(mshr_addr_hit),
        .miss_en(miss_en), .miss_waddr(miss_waddr), .miss_data(miss_data),
        .flush_req(flush_req), .flushing(flushing), .halt(halt)
    );

    typedef struct packed {
        logic [L-1:0]        ld_valid;
        logic [L*DW-1:0]     ld_value;
        logic                st_done, fill_ack, wr_en, wr_valid, wr_dirty;
        logic [AW-1:0]       wr_waddr;
        logic [DW-1:0]       wr_data;
        logic [L+1:0]        miss_en;
        logic [(L+2)*AW-1:0] miss_waddr;
        logic [(L+2)*DW-1:0] miss_data;
        logic                flushing, halt;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Model state: phase 0 idle, 1 walking lines, 2 waiting for MSHR drain, 3 finished.
    int   m_phase = 0;
    int   m_line  = 0;
    bit   m_prev_rst = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    always @(negedge clock) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("ld_valid",   256'(ld_valid),   256'(mon_e.ld_valid));
            chk("ld_value",   256'(ld_value),   256'(mon_e.ld_value));
            chk("st_done",    256'(st_done),    256'(mon_e.st_done));
            chk("fill_ack",   256'(fill_ack),   256'(mon_e.fill_ack));
            chk("wr_en",      256'(wr_en),      256'(mon_e.wr_en));
            chk("wr_valid",   256'(wr_valid),   256'(mon_e.wr_valid));
            chk("wr_dirty",   256'(wr_dirty),   256'(mon_e.wr_dirty));
            chk("wr_waddr",   256'(wr_waddr),   256'(mon_e.wr_waddr));
            chk("wr_data",    256'(wr_data),    256'(mon_e.wr_data));
            chk("miss_en",    256'(miss_en),    256'(mon_e.miss_en));
            chk("miss_waddr", 256'(miss_waddr), 256'(mon_e.miss_waddr));
            chk("miss_data",  256'(miss_data),  256'(mon_e.miss_data));
            chk("flushing",   256'(flushing),   256'(mon_e.flushing));
            chk("halt",       256'(halt),       256'(mon_e.halt));
        end
    end

    // Reference: derive this cycle's outputs from the current inputs, then advance the model.
    task automatic model_push();
        exp_t          e;
        logic [AW-1:0] seen[$];
        logic [AW-1:0] a;
        bit            found, can_evict, line_written;
        e = '0;
        can_evict = 1'b0;
        line_written = 1'b0;
        if (!(reset || m_prev_rst)) begin
            e.ld_valid = ld_en & ld_hit;
            e.ld_value = ld_rdata;
            for (int i = 0; i < L; i++) begin
                if (ld_en[i] && !ld_hit[i]) begin
                    a = ld_waddr[i*AW +: AW];
                    found = 1'b0;
                    foreach (seen[k]) if (seen[k] == a) found = 1'b1;
                    if (!found) begin
                        seen.push_back(a);
                        if (m_phase == 0 && !mshr_addr_hit[i] && mshr_ready) begin
                            e.miss_en[i] = 1'b1;
                            e.miss_waddr[i*AW +: AW] = a;
                            e.miss_data[i*DW +: DW] = 64'hDEADBEEFDEADBEEF;
                        end
                    end
                end
            end
            if (fill_en && mshr_ready) begin
                e.fill_ack = 1'b1;  e.wr_en = 1'b1;  e.wr_valid = 1'b1;
                e.wr_dirty = fill_dirty;  e.wr_waddr = fill_waddr;  e.wr_data = fill_data;
                can_evict = 1'b1;
            end else if (m_phase == 1) begin
                e.wr_waddr = AW'(m_line);
                e.wr_en = mshr_ready;
                can_evict = mshr_ready;
                line_written = mshr_ready;
            end else if (m_phase == 0 && st_en) begin
                e.wr_waddr = st_waddr;  e.wr_data = st_data;
                e.wr_valid = 1'b1;  e.wr_dirty = 1'b1;
                if (st_wr_hit) begin
                    e.wr_en = 1'b1;  e.st_done = 1'b1;
                end else if (!mshr_addr_hit[L] && mshr_ready) begin
                    e.st_done = 1'b1;  e.miss_en[L] = 1'b1;
                    e.miss_waddr[L*AW +: AW] = st_waddr;
                    e.miss_data[L*DW +: DW] = st_data;
                end
            end
            if (can_evict && ev_valid && ev_dirty) begin
                e.miss_en[L+1] = 1'b1;
                e.miss_waddr[(L+1)*AW +: AW] = ev_waddr;
                e.miss_data[(L+1)*DW +: DW] = ev_data;
            end
            e.flushing = (m_phase == 1) || (m_phase == 2);
            e.halt = (m_phase == 3) && mshr_empty;
        end
        expq.push_back(e);
        if (reset) begin
            m_phase = 0;  m_line = 0;
        end else if (!m_prev_rst) begin
            if (m_phase == 0 && flush_req) begin
                m_phase = 1;  m_line = 0;
            end else if (m_phase == 1 && line_written) begin
                if (m_line == NLINES - 1) m_phase = 2;
                else m_line++;
            end else if (m_phase == 2 && mshr_empty) begin
                m_phase = 3;
            end
        end
        m_prev_rst = reset;
    endtask

    task automatic step();
        model_push();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        ld_en = '0;  ld_hit = '0;  ld_waddr = '0;  ld_rdata = '0;
        st_en = 1'b0;  st_waddr = '0;  st_data = '0;  st_wr_hit = 1'b0;
        fill_en = 1'b0;  fill_waddr = '0;  fill_data = '0;  fill_dirty = 1'b0;
        ev_valid = 1'b0;  ev_dirty = 1'b0;  ev_waddr = '0;  ev_data = '0;
        mshr_ready = 1'b0;  mshr_empty = 1'b0;  mshr_addr_hit = '0;  flush_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] raddr();
        case ($urandom_range(0, 3))
            0:       return AW'(61'h10);
            1:       return AW'(61'h40);
            2:       return AW'(61'h80);
            default: return AW'(61'h200);
        endcase
    endfunction

    function automatic logic [DW-1:0] rdata();
        return {$urandom(), $urandom()};
    endfunction

    task automatic rand_inputs(input bit allow_reset, input bit fl);
        for (int i = 0; i < L; i++) begin
            ld_en[i] = 1'($urandom_range(0, 1));
            ld_hit[i] = 1'($urandom_range(0, 1));
            ld_waddr[i*AW +: AW] = raddr();
            ld_rdata[i*DW +: DW] = rdata();
        end
        st_en = 1'($urandom_range(0, 1));  st_waddr = raddr();  st_data = rdata();
        st_wr_hit = 1'($urandom_range(0, 1));
        fill_en = ($urandom_range(0, 3) == 0);  fill_waddr = raddr();  fill_data = rdata();
        fill_dirty = 1'($urandom_range(0, 1));
        ev_valid = 1'($urandom_range(0, 1));  ev_dirty = 1'($urandom_range(0, 1));
        ev_waddr = raddr();  ev_data = rdata();
        mshr_ready = ($urandom_range(0, 3) != 0);
        mshr_empty = 1'($urandom_range(0, 1));
        mshr_addr_hit = (L+1)'($urandom());
        flush_req = fl;
        reset = allow_reset && ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clock);
        #1;
        step();
        step();
        // Cycle after reset: active-looking inputs must still produce silent outputs.
        reset = 1'b0;
        ld_en = '1;  ld_hit = '1;  fill_en = 1'b1;  mshr_ready = 1'b1;  st_en = 1'b1;
        step();

        clr();  mshr_ready = 1'b1;
        ld_en = 2'b11;  ld_hit = 2'b01;
        ld_rdata[0 +: DW] = 64'h11;  ld_waddr[AW +: AW] = 61'h40;
        step();

        ld_hit = 2'b00;  ld_waddr[0 +: AW] = 61'h80;  ld_waddr[AW +: AW] = 61'h80;
        step();
        mshr_addr_hit[0] = 1'b1;
        step();

        clr();  mshr_ready = 1'b1;
        fill_en = 1'b1;  fill_waddr = 61'h10;  fill_data = 64'h5A;
        ev_valid = 1'b1;  ev_dirty = 1'b1;  ev_waddr = 61'h200;  ev_data = 64'h99;
        st_en = 1'b1;  st_wr_hit = 1'b1;  st_waddr = 61'h30;  st_data = 64'h77;
        step();
        fill_en = 1'b0;  ev_valid = 1'b0;  ev_dirty = 1'b0;
        step();

        clr();  fill_en = 1'b1;  fill_waddr = 61'h10;  st_en = 1'b1;  st_waddr = 61'h40;
        ev_valid = 1'b1;  ev_dirty = 1'b1;
        step();

        repeat (400) begin
            rand_inputs(1'b1, 1'b0);
            step();
        end

        reset = 1'b1;  clr();  step();  reset = 1'b0;  step();
        mshr_ready = 1'b1;  flush_req = 1'b1;  ev_valid = 1'b1;
        repeat (6) begin
            ev_dirty = (m_phase == 1) && (m_line == 1 || m_line == 3);
            ev_waddr = AW'(m_line + 16'h100);  ev_data = rdata();
            step();
        end
        ev_valid = 1'b0;  ev_dirty = 1'b0;
        repeat (4) step();
        mshr_empty = 1'b1;
        repeat (3) step();

        reset = 1'b1;  clr();  step();  reset = 1'b0;  step();
        mshr_ready = 1'b1;  flush_req = 1'b1;
        for (int k = 0; k < 10 && !(m_phase == 1 && m_line == 2); k++) step();
        reset = 1'b1;  step();
        reset = 1'b0;  flush_req = 1'b0;  step();
        step();
        flush_req = 1'b1;
        repeat (6) step();

        repeat (4) begin
            reset = 1'b1;  clr();  step();  reset = 1'b0;  step();
            repeat (60) begin
                rand_inputs(1'b0, 1'b1);
                step();
            end
        end

        for (int k = 0; k < 5 && expq.size() > 0; k++) @(negedge clock);
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl_mp.md
Name: dcache_ctrl_mp

Overview:
- Multi-port successor of the single-load/single-store data-cache controller. Sits between the LSQ (NUM_LD load ports, one store port), the cache data array (NUM_LD read ports, one write port) and the MSHR.
- Resolves hits, enqueues load/store misses and dirty evictions into the MSHR, and arbitrates the single array write port among fills, stores and flush.
- Runs an end-of-program flush FSM that walks every line, evicts dirty data and raises halt once the MSHR drains.

Parameters:
NUM_LD, 2, number of load ports (1..4)
NUM_LINES, 32, cache lines walked by flush (power of 2)
WADDR_W, 61, word-address width (byte address = {waddr,3'b000})
DATA_W, 64, data word width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
ld_en  in  NUM_LD  load request per port
ld_waddr  in  NUM_LD*WADDR_W  load word addresses
ld_hit  in  NUM_LD  array read hit per port (same cycle)
ld_rdata  in  NUM_LD*DATA_W  array read data
ld_valid  out  NUM_LD  load data valid
ld_value  out  NUM_LD*DATA_W  load data
st_en  in  1  store request
st_waddr  in  WADDR_W  store word address
st_data  in  DATA_W  store data
st_wr_hit  in  1  array write-port tag hit for current wr address
st_done  out  1  store retired (hit written or miss enqueued)
fill_en  in  1  MSHR fill/writeback line ready
fill_waddr  in  WADDR_W  fill address
fill_data  in  DATA_W  fill data
fill_dirty  in  1  fill dirty bit
fill_ack  out  1  fill consumed this cycle
wr_en, wr_valid, wr_dirty  out  1 each  array write controls
wr_waddr  out  WADDR_W  array write address (also tag-lookup address)
wr_data  out  DATA_W  array write data
ev_valid, ev_dirty  in  1 each  victim of current write
ev_waddr  in  WADDR_W  victim address
ev_data  in  DATA_W  victim data
mshr_ready  in  1  MSHR can accept all enqueues this cycle
mshr_empty  in  1  MSHR holds no entries
mshr_addr_hit  in  NUM_LD+1  address already pending (loads, then store)
miss_en  out  NUM_LD+2  enqueue: [NUM_LD-1:0] loads, [NUM_LD] store, [NUM_LD+1] evict
miss_waddr  out  (NUM_LD+2)*WADDR_W  enqueue addresses
miss_data  out  (NUM_LD+2)*DATA_W  enqueue data (loads 64'hDEADBEEFDEADBEEF)
flush_req  in  1  program done, begin flush (level)
flushing  out  1  FSM in FLUSH or DRAIN
halt  out  1  flush complete and MSHR empty

Behaviour:
- Loads are combinational, zero latency: ld_valid[i] = ld_en[i] & ld_hit[i]; ld_value[i] = ld_rdata[i].
- Load miss enqueue: miss_en[i] = ld_en[i] & !ld_hit[i] & !mshr_addr_hit[i] & mshr_ready & !dup[i].
  - dup[i] = some lower port j<i also misses with the same waddr in the same cycle. Only the lowest such port enqueues.
- Write-port grant priority: fill > flush > store. Exactly one source owns wr_* per cycle.
- Fill grant:
  - fill_ack = fill_en & mshr_ready.
  - wr_en = 1, wr_valid = 1, wr_dirty = fill_dirty.
- Flush grant (FSM in FLUSH, no fill_ack):
  - wr_waddr = idx<<0 (line index zero-extended), wr_valid = 0.
  - wr_en = mshr_ready; idx advances only when wr_en is asserted.
- Store grant (st_en, no fill/flush owner):
  - On hit: wr_en = 1, wr_dirty = 1, st_done = 1.
  - On miss with !mshr_addr_hit[NUM_LD] & mshr_ready: miss_en[NUM_LD] = 1, st_done = 1.
  - On miss with mshr_addr_hit[NUM_LD]: st_done = 0, store holds.
- A store that loses arbitration gets st_done = 0; the LSQ holds st_* stable.
- Evict enqueue: miss_en[NUM_LD+1] = wr_en & (fill or flush owner) & ev_valid & ev_dirty. A write is never performed unless mshr_ready, so evictions are never lost.
- When no source owns the port: wr_en = 0, wr_* = 0.
- Flush FSM, 2-bit state:
  - IDLE -> FLUSH on flush_req.
  - FLUSH -> DRAIN when a flush write occurs with idx == NUM_LINES-1.
  - DRAIN -> DONE when mshr_empty.
  - DONE is terminal until reset.
- idx is $clog2(NUM_LINES) bits. It is cleared on entering FLUSH and never wraps inside FLUSH.
- flushing = (FLUSH|DRAIN); halt = (DONE & mshr_empty).
- Fills are still accepted in FLUSH and DRAIN (MSHR must drain). Stores and loads are not expected after flush_req; if present they are serviced normally in IDLE only, and in FLUSH/DRAIN/DONE st_done = 0 and load misses are not enqueued.
- Reset (any cycle, including mid-flush): state = IDLE, idx = 0.
  - All registered state cleared; every output driven 0 in the reset cycle and the cycle after.

Test Plan:
- NUM_LD=2: both ports ld_en, port0 hit data 0x11, port1 miss waddr 0x40, mshr_ready=1 -> ld_valid=2'b01, ld_value[0]=0x11, miss_en=4'b0010, miss_waddr[1]=0x40.
- Both load ports miss same waddr 0x80 -> only miss_en[0]=1; with mshr_addr_hit[0]=1 -> no load enqueue.
- Same cycle fill_en (waddr 0x10, victim dirty 0x99 @0x200) and store hit -> wr_waddr=0x10, fill_ack=1, miss_en[3]=1 with data 0x99, st_done=0; next cycle store written with wr_dirty=1, st_done=1.
- mshr_ready=0 with fill_en and store miss -> fill_ack=0, wr_en=0, miss_en=0, st_done=0.
- flush_req, NUM_LINES=4, mshr_ready always 1, lines 1 and 3 dirty -> 4 flush writes idx 0..3 with wr_valid=0, evict enqueued twice, then DRAIN; mshr_empty after 5 cycles -> halt=1.
- Reset asserted at idx=2 in FLUSH -> next cycle state IDLE, flushing=0, halt=0; a new flush_req restarts at idx 0.
